fetch_unit: RTL

Instruction fetch stage for the switch-ROM CPU series. Sits directly upstream of the execute register: owns the program counter, drives the ROM address and latches ROM data into an instruction register once per divided-clock tick. Accepts jump and halt requests back from the execute stage. Replaces the free-running address generator with a controllable, restartable one.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_pc_counter.sv | 38 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/execute pipeline: fetch state encoding and
// default datapath widths.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: synchronous reset, enable-gated clear / load / wrapping increment.
module pc_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         ld,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc
);

    logic [W-1:0] pc_r;

    // PC register; clear beats load beats increment, all gated by en.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= '0;
        end else if (en) begin
            if (clr) begin
                pc_r <= '0;
            end else if (ld) begin
                pc_r <= load_val;
            end else if (inc) begin
                pc_r <= pc_r + {{(W-1){1'b0}}, 1'b1};
            end else begin
                pc_r <= pc_r;
            end
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches ROM words into IR once per tick,
// and honours halt/jump requests from the execute stage.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TICK,
    input  logic              START,
    input  logic [DATA_W-1:0] ROM_DATA,
    input  logic              JMP,
    input  logic [ADDR_W-1:0] JMP_ADR,
    input  logic              HALT,
    output logic [ADDR_W-1:0] ADR,
    output logic [DATA_W-1:0] IR,
    output logic              IR_VALID,
    output logic              RUNNING
);

    fetch_state_e      state_r;
    logic [DATA_W-1:0] ir_r;
    logic              ir_valid_r;
    logic              running_r;
    logic              pc_clr_s;
    logic              pc_ld_s;
    logic              pc_inc_s;

    // PC control decode from the current state and execute-stage requests.
    always_comb begin
        pc_clr_s = 1'b0;
        pc_ld_s  = 1'b0;
        pc_inc_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (HALT) begin
                    pc_inc_s = 1'b0;
                end else if (JMP) begin
                    pc_ld_s = 1'b1;
                end else begin
                    pc_inc_s = 1'b1;
                end
            end
            ST_STOP: begin
                if (!START) begin
                    pc_clr_s = 1'b1;
                end else begin
                    pc_clr_s = 1'b0;
                end
            end
            default: begin
                pc_clr_s = 1'b0;
            end
        endcase
    end

    pc_counter #(.W(ADDR_W)) u_pc (
        .clk      (CLK),
        .rst      (RST),
        .en       (TICK),
        .clr      (pc_clr_s),
        .ld       (pc_ld_s),
        .inc      (pc_inc_s),
        .load_val (JMP_ADR),
        .pc       (ADR)
    );

    // Fetch FSM with IR and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
            running_r  <= 1'b0;
        end else if (TICK) begin
            case (state_r)
                ST_IDLE: begin
                    ir_valid_r <= 1'b0;
                    if (START) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (HALT) begin
                        state_r    <= ST_STOP;
                        running_r  <= 1'b0;
                        ir_valid_r <= 1'b0;
                    end else if (JMP) begin
                        // The word fetched this tick is from the old path; drop it.
                        ir_valid_r <= 1'b0;
                    end else begin
                        ir_r       <= ROM_DATA;
                        ir_valid_r <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!START) begin
                        state_r    <= ST_IDLE;
                        ir_r       <= '0;
                        ir_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    running_r  <= 1'b0;
                    ir_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign IR       = ir_r;
    assign IR_VALID = ir_valid_r;
    assign RUNNING  = running_r;

endmodule
